// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard interface: ID-stage issue info, downstream stage
// destinations and memory waits in; pipeline control and forwarding out.
interface hazard_scoreboard_if #(
    parameter int NREGS      = 32,
    parameter int NUM_RS     = 2,
    parameter int FWD_STAGES = 3,
    parameter int CNT_W      = 16
);
    localparam int REG_BITS = $clog2(NREGS);
    localparam int FSEL_W   = $clog2(FWD_STAGES + 1);

    logic                           issue_valid;
    logic                           issue_write;
    logic [REG_BITS-1:0]            issue_rd;
    logic [1:0]                     issue_class;
    logic [NUM_RS*REG_BITS-1:0]     rs;
    logic [NUM_RS-1:0]              rs_used;
    logic [FWD_STAGES*REG_BITS-1:0] stage_rd;
    logic [FWD_STAGES-1:0]          stage_write;
    logic                           branch_taken;
    logic                           imem_wait;
    logic                           dmem_wait;
    logic                           pipe_enable;
    logic                           stall;
    logic                           flush_ifid;
    logic [NUM_RS*FSEL_W-1:0]       fwd_sel;
    logic [NREGS-1:0]               busy_mask;
    logic [CNT_W-1:0]               stall_count;

    modport master (
        output issue_valid, issue_write, issue_rd, issue_class, rs, rs_used,
               stage_rd, stage_write, branch_taken, imem_wait, dmem_wait,
        input  pipe_enable, stall, flush_ifid, fwd_sel, busy_mask, stall_count
    );

    modport slave (
        input  issue_valid, issue_write, issue_rd, issue_class, rs, rs_used,
               stage_rd, stage_write, branch_taken, imem_wait, dmem_wait,
        output pipe_enable, stall, flush_ifid, fwd_sel, busy_mask, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: per-register bubble counters for long-latency
// results, RAW/WAW stall generation, branch flush and forwarding select.
module hazard_scoreboard #(
    parameter int NREGS      = 32,
    parameter int NUM_RS     = 2,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_LAT   = 1,
    parameter int MUL_LAT    = 3,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave sb
);
    localparam int REG_BITS = $clog2(NREGS);
    localparam int MAX_LAT  = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
    localparam int LAT_W    = $clog2(MAX_LAT + 1);
    localparam int FSEL_W   = $clog2(FWD_STAGES + 1);

    logic [LAT_W-1:0] cnt      [NREGS];
    logic [LAT_W-1:0] cnt_next [NREGS];
    logic             raw;
    logic             waw;
    logic             do_issue;
    logic             load_en;
    logic [LAT_W-1:0] load_val;

    // Hazard detection against pending counters; x0 never hazards.
    always_comb begin
        raw = 1'b0;
        for (int unsigned k = 0; k < NUM_RS; k++) begin
            if (sb.rs_used[k] && sb.rs[k*REG_BITS +: REG_BITS] != '0 &&
                cnt[sb.rs[k*REG_BITS +: REG_BITS]] != '0)
                raw = 1'b1;
        end
        waw = sb.issue_write && sb.issue_rd != '0 && cnt[sb.issue_rd] != '0;
    end

    // Pipeline control: branch redirect overrides any stall.
    always_comb begin
        sb.pipe_enable = !(sb.imem_wait || sb.dmem_wait);
        sb.stall       = sb.issue_valid && (raw || waw) && !sb.branch_taken;
        sb.flush_ifid  = sb.branch_taken;
        do_issue       = sb.issue_valid && sb.pipe_enable && !sb.stall && !sb.branch_taken;
    end

    // Latency load for an issuing LOAD/MUL that writes a real register.
    always_comb begin
        load_val = (sb.issue_class == 2'd2) ? LAT_W'(MUL_LAT) : LAT_W'(LOAD_LAT);
        load_en  = do_issue && sb.issue_write && sb.issue_rd != '0 &&
                   (sb.issue_class == 2'd1 || sb.issue_class == 2'd2);
    end

    // Next counter values: a load wins over the decrement; x0 pinned to 0.
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_next[r] = cnt[r];
            if (sb.pipe_enable && cnt[r] != '0)
                cnt_next[r] = cnt[r] - LAT_W'(1);
            if (load_en && sb.issue_rd == REG_BITS'(r))
                cnt_next[r] = load_val;
            if (r == 0)
                cnt_next[r] = '0;
        end
    end

    // Forwarding select: scan oldest to youngest so the youngest match wins.
    always_comb begin
        sb.fwd_sel = '0;
        for (int unsigned k = 0; k < NUM_RS; k++) begin
            for (int unsigned s = FWD_STAGES; s > 0; s--) begin
                if (sb.rs_used[k] && sb.rs[k*REG_BITS +: REG_BITS] != '0 &&
                    sb.stage_write[s-1] &&
                    sb.stage_rd[(s-1)*REG_BITS +: REG_BITS] == sb.rs[k*REG_BITS +: REG_BITS])
                    sb.fwd_sel[k*FSEL_W +: FSEL_W] = FSEL_W'(s);
            end
        end
    end

    // State update: counters, busy mask and saturating stall counter freeze
    // whenever the pipeline is held by a memory wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++)
                cnt[r] <= '0;
            sb.busy_mask   <= '0;
            sb.stall_count <= '0;
        end else if (sb.pipe_enable) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                cnt[r]          <= cnt_next[r];
                sb.busy_mask[r] <= (cnt_next[r] != '0);
            end
            if (sb.stall && sb.stall_count != '1)
                sb.stall_count <= sb.stall_count + CNT_W'(1);
        end
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREGS, default 32: architectural register count; REG_BITS = clog2(NREGS).
REQ-002 Parameter NUM_RS, default 2: number of ID-stage source read ports.
REQ-003 Parameter FWD_STAGES, default 3: forwardable stages; index 0 = EX (youngest), then MEM, then WB.
REQ-004 Parameter LOAD_LAT, default 1: bubbles a load result needs before it can be forwarded.
REQ-005 Parameter MUL_LAT, default 3: bubbles a multi-cycle multiply result needs before it can be forwarded.
REQ-006 Parameter CNT_W, default 16: width of the stall performance counter.
REQ-007 Derived: LAT_W = clog2(max(LOAD_LAT, MUL_LAT) + 1); FSEL_W = clog2(FWD_STAGES + 1).
REQ-008 clk  in  1  sole clock; all state updates on its rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 issue_valid  in  1  valid instruction in ID.
REQ-011 issue_write  in  1  ID instruction writes rd.
REQ-012 issue_rd  in  REG_BITS  ID destination register.
REQ-013 issue_class  in  2  0 = ALU, 1 = LOAD, 2 = MUL, 3 = treated as ALU.
REQ-014 rs  in  NUM_RS*REG_BITS  ID source registers; port k occupies bits [k*REG_BITS +: REG_BITS].
REQ-015 rs_used  in  NUM_RS  per-port source-in-use flag.
REQ-016 stage_rd  in  FWD_STAGES*REG_BITS  destination register per downstream stage.
REQ-017 stage_write  in  FWD_STAGES  per-stage write_reg.
REQ-018 branch_taken  in  1  redirect resolved this cycle.
REQ-019 imem_wait, dmem_wait  in  1 each  memory wait.
REQ-020 pipe_enable  out  1  global pipeline advance enable.
REQ-021 stall  out  1  hold PC and IF/ID; insert bubble into EX.
REQ-022 flush_ifid  out  1  squash IF/ID contents.
REQ-023 fwd_sel  out  NUM_RS*FSEL_W  per port: 0 = register file, s+1 = stage s.
REQ-024 busy_mask  out  NREGS  registered; bit r = scoreboard counter r nonzero.
REQ-025 stall_count  out  CNT_W  registered; saturating count of stall cycles.

Function
REQ-026 pipe_enable SHALL be !(imem_wait || dmem_wait).
REQ-027 Per-register counter cnt[r] (LAT_W bits) SHALL hold the remaining bubbles before r is forwardable; cnt[0] SHALL always read 0.
REQ-028 RAW SHALL be asserted when, for any port k: rs_used[k], rs[k] != 0 and cnt[rs[k]] != 0.
REQ-029 WAW SHALL be asserted when: issue_write, issue_rd != 0 and cnt[issue_rd] != 0.
REQ-030 stall SHALL be issue_valid && (RAW || WAW) && !branch_taken.
REQ-031 flush_ifid SHALL equal branch_taken; branch_taken overrides stall in the same cycle.
REQ-032 Issue SHALL be issue_valid && pipe_enable && !stall && !branch_taken.
REQ-033 On issue with issue_write, rd != 0 and class LOAD or MUL, cnt[rd] SHALL be loaded with LOAD_LAT or MUL_LAT at the next edge; ALU issue SHALL leave all counters unchanged.
REQ-034 While pipe_enable = 1, every nonzero counter not being loaded SHALL decrement by 1 per cycle; a load to the same register in the same cycle SHALL win over the decrement.
REQ-035 While pipe_enable = 0, all counters, busy_mask and stall_count SHALL hold.
REQ-036 fwd_sel[k] SHALL be the lowest stage s with stage_write[s] and stage_rd[s] == rs[k], encoded as s+1; it SHALL be 0 if rs[k] == 0, if rs_used[k] = 0, or if no stage matches.
REQ-037 busy_mask SHALL reflect the post-update counters one cycle after the update.
REQ-038 stall_count SHALL increment when stall && pipe_enable, and SHALL saturate at 2^CNT_W - 1 without wrapping.

Reset
REQ-039 On reset, all counters, busy_mask and stall_count SHALL clear to 0; combinational outputs then follow from zero state (stall = 0, fwd_sel per stage inputs).
REQ-040 Reset asserted mid-latency SHALL discard all pending counts; no stall SHALL originate from pre-reset issues.

Verification
REQ-041 LOAD x5 issued at t; next instruction reads x5 at t+1 -> stall = 1 for exactly 1 cycle; at t+2 stall = 0 and fwd_sel = 2 (MEM).
REQ-042 MUL x7 issued at t; dependent instruction reads x7 -> 3 stall cycles; busy_mask[7] = 1 from t+1 through t+3; stall_count += 3.
REQ-043 LOAD x5 pending, dmem_wait held 4 cycles -> pipe_enable = 0, counter and stall_count frozen; stall resumes and ends after 1 enabled cycle.
REQ-044 Dependent instruction stalled and branch_taken = 1 in the same cycle -> stall = 0, flush_ifid = 1, no counter loaded.
REQ-045 rs = x0 with all stages writing x0; WAW to busy x9 -> fwd_sel = 0, no RAW stall on x0; stall asserted until cnt[9] = 0.
REQ-046 Reset during MUL countdown (cnt = 2) -> busy_mask = 0 next cycle; a dependent read does not stall; stall_count forced to 2^CNT_W - 1 stays saturated on a further stall.
